// File: rtl/mac_arbiter_if.sv
// rtl/mac_arbiter_if.sv - Requester, MAC operand and response bus of the shared-MAC scheduler
//
// Signals:
//   req_valid  [NREQ]           requester i presents operands
//   req_a/b/c  [NREQ*SIZE]      packed operands, slice i is [i*SIZE +: SIZE]
//   req_ready  [NREQ]           one-hot grant
//   mac_a/b/c  [SIZE]           operands to the MAC
//   mac_result [OUT_SIZE]       MAC output
//   rsp_valid/rsp_id/rsp_data   tagged result
//   op_count   [16]             completed results, wraps
// Modports: slave = the scheduler, master = requesters, MAC and response sink.
interface mac_arbiter_if #(
    parameter int SIZE     = 8,
    parameter int OUT_SIZE = 16,
    parameter int NREQ     = 4,
    parameter int IDW      = $clog2(NREQ)
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*SIZE-1:0] req_a;
    logic [NREQ*SIZE-1:0] req_b;
    logic [NREQ*SIZE-1:0] req_c;
    logic [NREQ-1:0]      req_ready;
    logic [SIZE-1:0]      mac_a;
    logic [SIZE-1:0]      mac_b;
    logic [SIZE-1:0]      mac_c;
    logic [OUT_SIZE-1:0]  mac_result;
    logic                 rsp_valid;
    logic [IDW-1:0]       rsp_id;
    logic [OUT_SIZE-1:0]  rsp_data;
    logic [15:0]          op_count;

    modport slave (
        input  req_valid, req_a, req_b, req_c, mac_result,
        output req_ready, mac_a, mac_b, mac_c, rsp_valid, rsp_id, rsp_data, op_count
    );

    modport master (
        output req_valid, req_a, req_b, req_c, mac_result,
        input  req_ready, mac_a, mac_b, mac_c, rsp_valid, rsp_id, rsp_data, op_count
    );
endinterface

// File: rtl/mac_arbiter.sv
// rtl/mac_arbiter.sv - Scheduler sharing one 3-stage pipelined multiply-add unit between NREQ requesters
//
// Ports:
//   clock  rising-edge clock
//   reset  synchronous, active-high reset
//   bus    mac_arbiter_if.slave: requester handshake, MAC operands/result, tagged response, op_count
//
// Configuration macro MAC_ARB_RR_EN:
//   defined   -> round-robin grant starting at a pointer that moves past each winner
//   undefined -> fixed priority, lowest valid index wins (no pointer state)
module mac_arbiter #(
    parameter int SIZE     = 8,
    parameter int OUT_SIZE = 16,
    parameter int NREQ     = 4,
    parameter int MAC_LAT  = 3,
    parameter int IDW      = $clog2(NREQ)
) (
    input  logic         clock,
    input  logic         reset,
    mac_arbiter_if.slave bus
);
    logic                      gnt_found;
    logic [IDW-1:0]            gnt_idx;
    logic [IDW-1:0]            cand;

    logic [SIZE-1:0]           mac_a_q, mac_a_d;
    logic [SIZE-1:0]           mac_b_q, mac_b_d;
    logic [SIZE-1:0]           mac_c_q, mac_c_d;
    // Tag pipe: entry 0 is loaded at the accept edge, entry MAC_LAT lines up with mac_result.
    logic [MAC_LAT:0]          tag_v_q, tag_v_d;
    logic [MAC_LAT:0][IDW-1:0] tag_id_q, tag_id_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]            rsp_id_q, rsp_id_d;
    logic [OUT_SIZE-1:0]       rsp_data_q, rsp_data_d;
    logic [15:0]               op_count_q, op_count_d;
`ifdef MAC_ARB_RR_EN
    logic [IDW-1:0]            ptr_q, ptr_d;
`endif

    // Grant search; the first hit wins. Suppressed during reset so nothing is accepted.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
`ifdef MAC_ARB_RR_EN
            cand = IDW'((int'(ptr_q) + k) % NREQ);
`else
            cand = IDW'(k);
`endif
            if (!gnt_found && bus.req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
        if (reset) begin
            gnt_found = 1'b0;
        end
    end

    assign bus.req_ready = gnt_found ? (NREQ'(1) << gnt_idx) : '0;

    always_comb begin
        mac_a_d     = '0;
        mac_b_d     = '0;
        mac_c_d     = '0;
        if (gnt_found) begin
            mac_a_d = bus.req_a[int'(gnt_idx) * SIZE +: SIZE];
            mac_b_d = bus.req_b[int'(gnt_idx) * SIZE +: SIZE];
            mac_c_d = bus.req_c[int'(gnt_idx) * SIZE +: SIZE];
        end

        tag_v_d     = {tag_v_q[MAC_LAT-1:0], gnt_found};
        tag_id_d    = {tag_id_q[MAC_LAT-1:0], gnt_idx};

        // Response fields hold their last value between results.
        rsp_valid_d = tag_v_q[MAC_LAT];
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        op_count_d  = op_count_q;
        if (tag_v_q[MAC_LAT]) begin
            rsp_id_d   = tag_id_q[MAC_LAT];
            rsp_data_d = bus.mac_result;
            op_count_d = op_count_q + 16'd1;
        end

`ifdef MAC_ARB_RR_EN
        ptr_d = ptr_q;
        if (gnt_found) begin
            ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mac_a_q     <= '0;
            mac_b_q     <= '0;
            mac_c_q     <= '0;
            tag_v_q     <= '0;
            tag_id_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            op_count_q  <= '0;
`ifdef MAC_ARB_RR_EN
            ptr_q       <= '0;
`endif
        end else begin
            mac_a_q     <= mac_a_d;
            mac_b_q     <= mac_b_d;
            mac_c_q     <= mac_c_d;
            tag_v_q     <= tag_v_d;
            tag_id_q    <= tag_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            op_count_q  <= op_count_d;
`ifdef MAC_ARB_RR_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign bus.mac_a     = mac_a_q;
    assign bus.mac_b     = mac_b_q;
    assign bus.mac_c     = mac_c_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.op_count  = op_count_q;
endmodule

// File: tb/tb_mac_arbiter.sv
// tb/tb_mac_arbiter.sv - Randomized self-checking bench for mac_arbiter with a MAC model and reference scoreboard
module tb_mac_arbiter;
    localparam int SIZE     = 8;
    localparam int OUT_SIZE = 16;
    localparam int NREQ     = 4;
    localparam int MAC_LAT  = 3;
    localparam int IDW      = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    mac_arbiter_if #(.SIZE(SIZE), .OUT_SIZE(OUT_SIZE), .NREQ(NREQ), .IDW(IDW)) bus ();

    mac_arbiter #(.SIZE(SIZE), .OUT_SIZE(OUT_SIZE), .NREQ(NREQ), .MAC_LAT(MAC_LAT), .IDW(IDW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Shared MAC: capture, multiply, add, one register each.
    logic [SIZE-1:0]     s1_a, s1_b, s1_c;
    logic [OUT_SIZE-1:0] s2_p, s2_c, s3_r;
    always @(posedge clock) begin
        s1_a <= bus.mac_a;
        s1_b <= bus.mac_b;
        s1_c <= bus.mac_c;
        s2_p <= OUT_SIZE'(s1_a) * OUT_SIZE'(s1_b);
        s2_c <= OUT_SIZE'(s1_c);
        s3_r <= s2_p + s2_c;
    end
    assign bus.mac_result = s3_r;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Requester-side state owned by the driver.
    logic [NREQ-1:0] pend;
    logic [SIZE-1:0] opa [NREQ];
    logic [SIZE-1:0] opb [NREQ];
    logic [SIZE-1:0] opc [NREQ];

    // Reference model state.
    typedef struct {
        int                  due;
        int                  id;
        logic [OUT_SIZE-1:0] data;
    } rsp_t;
    rsp_t            exp_q [$];
    int              grants [$];
    int              m_ptr      = 0;
    logic [15:0]     m_cnt      = '0;
    int              last_id    = 0;
    logic [OUT_SIZE-1:0] last_data = '0;
    logic [SIZE-1:0] e_a = '0, e_b = '0, e_c = '0;
    bit              post_reset = 1'b0;

    always @(negedge clock) begin
        if (reset) begin
            check_eq("ready_in_reset", 32'(bus.req_ready), 32'd0);
            exp_q.delete();
            m_ptr      = 0;
            m_cnt      = '0;
            last_id    = 0;
            last_data  = '0;
            e_a        = '0;
            e_b        = '0;
            e_c        = '0;
            post_reset = 1'b1;
        end else if (post_reset) begin
            int  g;
            bit  exp_v;
            exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            if (exp_v) begin
                last_id   = exp_q[0].id;
                last_data = exp_q[0].data;
                m_cnt     = m_cnt + 16'd1;
                void'(exp_q.pop_front());
            end
            check_eq("rsp_valid", 32'(bus.rsp_valid), 32'(exp_v));
            check_eq("rsp_id",    32'(bus.rsp_id),    32'(last_id));
            check_eq("rsp_data",  32'(bus.rsp_data),  32'(last_data));
            check_eq("op_count",  32'(bus.op_count),  32'(m_cnt));
            check_eq("mac_a",     32'(bus.mac_a),     32'(e_a));
            check_eq("mac_b",     32'(bus.mac_b),     32'(e_b));
            check_eq("mac_c",     32'(bus.mac_c),     32'(e_c));

            // Winner: first valid requester scanning from the pointer (or from 0).
            g = -1;
            for (int k = 0; k < NREQ; k++) begin
                int idx;
`ifdef MAC_ARB_RR_EN
                idx = (m_ptr + k) % NREQ;
`else
                idx = k;
`endif
                if (g < 0 && bus.req_valid[idx]) g = idx;
            end
            check_eq("req_ready", 32'(bus.req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);

            for (int k = 0; k < NREQ; k++) begin
                if (bus.req_ready[k]) grants.push_back(k);
            end

            if (g >= 0) begin
                rsp_t r;
                r.due  = cyc + 5;
                r.id   = g;
                r.data = OUT_SIZE'((int'(opa[g]) * int'(opb[g]) + int'(opc[g])) % 65536);
                exp_q.push_back(r);
                e_a   = opa[g];
                e_b   = opb[g];
                e_c   = opc[g];
                m_ptr = (g + 1) % NREQ;
            end else begin
                e_a = '0;
                e_b = '0;
                e_c = '0;
            end
        end
    end

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[i*SIZE +: SIZE] = opa[i];
            bus.req_b[i*SIZE +: SIZE] = opb[i];
            bus.req_c[i*SIZE +: SIZE] = opc[i];
        end
        bus.req_valid = pend;
    endtask

    // One clock: note accepted requests at the negedge, drop them just after the edge.
    task automatic tick();
        logic [NREQ-1:0] acc;
        @(negedge clock);
        acc = bus.req_valid & bus.req_ready;
        @(posedge clock);
        #1;
        pend = pend & ~acc;
    endtask

    task automatic set_req(input int i, input logic [SIZE-1:0] a, input logic [SIZE-1:0] b, input logic [SIZE-1:0] c);
        opa[i]  = a;
        opb[i]  = b;
        opc[i]  = c;
        pend[i] = 1'b1;
    endtask

    task automatic idle(input int n);
        pend = '0;
        drive();
        repeat (n) tick();
    endtask

    task automatic do_reset();
        pend  = '0;
        drive();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    initial begin
        pend = '0;
        for (int i = 0; i < NREQ; i++) begin
            opa[i] = '0;
            opb[i] = '0;
            opc[i] = '0;
        end
        drive();
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        // Single op.
        set_req(0, 8'd3, 8'd5, 8'd7);
        drive();
        tick();
        idle(7);
        check_eq("single_op_count", 32'(bus.op_count), 32'd1);
        check_eq("single_op_data",  32'(bus.rsp_data), 32'd22);

        // Max operands followed directly by a small one.
        set_req(0, 8'd255, 8'd255, 8'd255);
        drive();
        tick();
        set_req(0, 8'd0, 8'd9, 8'd1);
        drive();
        tick();
        idle(7);
        check_eq("max_then_small_last", 32'(bus.rsp_data), 32'd1);

        // Reset while two ops are in flight.
        set_req(0, 8'd11, 8'd12, 8'd13);
        set_req(1, 8'd21, 8'd22, 8'd23);
        drive();
        tick();
        drive();
        tick();
        do_reset();
        idle(7);
        check_eq("post_reset_count", 32'(bus.op_count), 32'd0);
        set_req(2, 8'd10, 8'd20, 8'd30);
        drive();
        tick();
        idle(7);
        check_eq("after_reset_data", 32'(bus.rsp_data), 32'd230);
        check_eq("after_reset_id",   32'(bus.rsp_id),   32'd2);

        // Full contention, all requesters held valid for 8 cycles.
        do_reset();
        grants.delete();
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i]) set_req(i, SIZE'($urandom), SIZE'($urandom), SIZE'($urandom));
            end
            drive();
            tick();
        end
        idle(7);
        check_eq("contention_grants", 32'(grants.size()), 32'd8);
        for (int k = 0; k < 8 && k < grants.size(); k++) begin
`ifdef MAC_ARB_RR_EN
            check_eq("contention_order", 32'(grants[k]), 32'(k % NREQ));
`else
            check_eq("contention_order", 32'(grants[k]), 32'd0);
`endif
        end

        // Requesters 1 and 3 held valid for 4 cycles.
        do_reset();
        grants.delete();
        for (int c = 0; c < 4; c++) begin
            if (!pend[1]) set_req(1, SIZE'($urandom), SIZE'($urandom), SIZE'($urandom));
            if (!pend[3]) set_req(3, SIZE'($urandom), SIZE'($urandom), SIZE'($urandom));
            drive();
            tick();
        end
        idle(7);
        check_eq("pair_grants", 32'(grants.size()), 32'd4);
        for (int k = 0; k < 4 && k < grants.size(); k++) begin
`ifdef MAC_ARB_RR_EN
            check_eq("pair_order", 32'(grants[k]), (k % 2 == 0) ? 32'd1 : 32'd3);
`else
            check_eq("pair_order", 32'(grants[k]), 32'd1);
`endif
        end

        // Random traffic.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0)
                    set_req(i, SIZE'($urandom), SIZE'($urandom), SIZE'($urandom));
            end
            drive();
            tick();
        end
        idle(7);
        check_eq("random_drained", 32'(exp_q.size()), 32'd0);

        // op_count wrap: 65537 completions from a single always-valid requester.
        do_reset();
        for (int n = 0; n < 65537; n++) begin
            set_req(0, SIZE'($urandom), SIZE'($urandom), SIZE'($urandom));
            drive();
            tick();
        end
        idle(7);
        check_eq("wrap_count", 32'(bus.op_count), 32'd1);
        check_eq("final_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
